// File: rtl/i2s_tx_fifo_ser.sv
// i2s_tx_fifo_ser: stereo sample FIFO feeding an I2S serializer, single clock domain.
//
// Ports:
//   clk_i, rst_ni     system clock (rising edge), asynchronous active-low reset
//   en_i              serializer enable; a frame in flight always completes
//   stereo_i          1 = stereo, 0 = mono (left sample sent in both slots)
//   standard_i        00 Philips, 01 left-justified, 10 right-justified, 11 as 01
//   word_size_i       valid bits 8/16/24/32, clipped to SLOT_W
//   bit_en_i          one-clock strobe per serial bit period
//   wr_valid_i        write request; wr_ready_o = FIFO not full
//   din_l_i, din_r_i  LSB-aligned left/right samples
//   sd_o, ws_o        registered serial data (MSB first) and word select
//   underrun_o        sticky flag, cleared by underrun_clr_i (set wins)
//
// Optional feature, macro I2S_TXF_LEVEL_EN: adds level_o (entry count) and
// almost_empty_o (registered, level <= AE_THRESH, resets to 1).
module i2s_tx_fifo_ser #(
   parameter int unsigned SLOT_W    = 32,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned AE_THRESH = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   input  logic              stereo_i,
   input  logic [1:0]        standard_i,
   input  logic [1:0]        word_size_i,
   input  logic              bit_en_i,
   input  logic              wr_valid_i,
   output logic              wr_ready_o,
   input  logic [SLOT_W-1:0] din_l_i,
   input  logic [SLOT_W-1:0] din_r_i,
   output logic              sd_o,
   output logic              ws_o,
   input  logic              underrun_clr_i,
`ifdef I2S_TXF_LEVEL_EN
   output logic [$clog2(DEPTH+1)-1:0] level_o,
   output logic                       almost_empty_o,
`endif
   output logic              underrun_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(SLOT_W);
   localparam logic [CW-1:0] CntMax = CW'(SLOT_W - 1);
   localparam logic [5:0]    WFull  = 6'(SLOT_W);

   typedef enum logic [1:0] {StIdle, StLeft, StRight} state_e;

   // Valid bit count for a word_size code, clipped to the slot width.
   function automatic logic [5:0] clip_w(input logic [1:0] wsz);
      int w;
      w = 8 * (int'(wsz) + 1);
      if (w > int'(SLOT_W)) w = int'(SLOT_W);
      return 6'(w);
   endfunction

   // Bit driven at slot position p for sample s of width w in format std.
   function automatic logic slot_bit(input logic [SLOT_W-1:0] s, input int p, input int w,
                                     input logic [1:0] std, input logic carry);
      logic [SLOT_W-1:0] sh;
      int                idx;
      logic              hit;
      logic              b;
      idx = 0;
      hit = 1'b0;
      b   = 1'b0;
      case (std)
         2'b00: begin
            // Philips: one-bit delay, p=0 carries the previous word's spill-over
            if (p == 0) b = carry;
            else if (p <= w) begin
               hit = 1'b1;
               idx = w - p;
            end
         end
         2'b10: begin
            if (p >= int'(SLOT_W) - w) begin
               hit = 1'b1;
               idx = int'(SLOT_W) - 1 - p;
            end
         end
         default: begin
            if (p < w) begin
               hit = 1'b1;
               idx = w - 1 - p;
            end
         end
      endcase
      sh = s >> idx;
      if (hit) b = sh[0];
      return b;
   endfunction

   // FIFO
   logic [2*SLOT_W-1:0] mem_q [DEPTH];
   logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                empty, full, push, pop;
   logic [SLOT_W-1:0]   head_l, head_r;

   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign wr_ready_o = ~full;
   assign push       = wr_valid_i & ~full;
   assign {head_r, head_l} = mem_q[rd_ptr_q[AW-1:0]];
   assign wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
   assign rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {din_r_i, din_l_i};
   end

   // Serializer
   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [SLOT_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
   logic [1:0]        std_q, std_d;
   logic [5:0]        w_q, w_d;
   logic              carry_q, carry_d;
   logic              sd_q, sd_d, ws_q, ws_d;
   logic              underrun_q, underrun_d;
   logic              set_ur, slot_end, fin_carry;
   logic [1:0]        new_std;
   logic [5:0]        new_w;
   logic [SLOT_W-1:0] nxt_l, nxt_r;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sh_l_d   = sh_l_q;
      sh_r_d   = sh_r_q;
      std_d    = std_q;
      w_d      = w_q;
      carry_d  = carry_q;
      sd_d     = sd_q;
      ws_d     = ws_q;
      set_ur   = 1'b0;
      pop      = 1'b0;
      slot_end = (cnt_q == CntMax);
      new_std  = standard_i;
      new_w    = clip_w(word_size_i);
      // LSB of a full-width Philips word spills into the next slot's first bit
      fin_carry = (std_q == 2'b00 && w_q == WFull) ?
                  ((state_q == StRight) ? sh_r_q[0] : sh_l_q[0]) : 1'b0;
      nxt_l = empty ? '0 : head_l;
      nxt_r = empty ? '0 : (stereo_i ? head_r : head_l);
      if (bit_en_i) begin
         unique case (state_q)
            StIdle: begin
               if (en_i && !empty) begin
                  pop     = 1'b1;
                  state_d = StLeft;
                  cnt_d   = '0;
                  std_d   = new_std;
                  w_d     = new_w;
                  sh_l_d  = nxt_l;
                  sh_r_d  = nxt_r;
                  carry_d = 1'b0;
                  sd_d    = slot_bit(nxt_l, 0, int'(new_w), new_std, 1'b0);
                  ws_d    = 1'b0;
               end else begin
                  sd_d = 1'b0;
                  ws_d = 1'b0;
               end
            end
            StLeft: begin
               if (slot_end) begin
                  state_d = StRight;
                  cnt_d   = '0;
                  carry_d = fin_carry;
                  sd_d    = slot_bit(sh_r_q, 0, int'(w_q), std_q, fin_carry);
                  ws_d    = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
                  sd_d  = slot_bit(sh_l_q, int'(cnt_q) + 1, int'(w_q), std_q, carry_q);
                  ws_d  = 1'b0;
               end
            end
            StRight: begin
               if (slot_end) begin
                  if (en_i) begin
                     // Empty FIFO here sends a zero frame but keeps ws running
                     pop     = ~empty;
                     set_ur  = empty;
                     state_d = StLeft;
                     cnt_d   = '0;
                     std_d   = new_std;
                     w_d     = new_w;
                     sh_l_d  = nxt_l;
                     sh_r_d  = nxt_r;
                     carry_d = fin_carry;
                     sd_d    = slot_bit(nxt_l, 0, int'(new_w), new_std, fin_carry);
                     ws_d    = 1'b0;
                  end else begin
                     state_d = StIdle;
                     cnt_d   = '0;
                     carry_d = 1'b0;
                     sd_d    = 1'b0;
                     ws_d    = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
                  sd_d  = slot_bit(sh_r_q, int'(cnt_q) + 1, int'(w_q), std_q, carry_q);
                  ws_d  = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
      underrun_d = set_ur ? 1'b1 : (underrun_clr_i ? 1'b0 : underrun_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         state_q    <= StIdle;
         cnt_q      <= '0;
         sh_l_q     <= '0;
         sh_r_q     <= '0;
         std_q      <= '0;
         w_q        <= '0;
         carry_q    <= 1'b0;
         sd_q       <= 1'b0;
         ws_q       <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_l_q     <= sh_l_d;
         sh_r_q     <= sh_r_d;
         std_q      <= std_d;
         w_q        <= w_d;
         carry_q    <= carry_d;
         sd_q       <= sd_d;
         ws_q       <= ws_d;
         underrun_q <= underrun_d;
      end
   end

   assign sd_o       = sd_q;
   assign ws_o       = ws_q;
   assign underrun_o = underrun_q;

`ifdef I2S_TXF_LEVEL_EN
   logic [AW:0] lvl_d;
   logic        ae_q;

   assign lvl_d = wr_ptr_d - rd_ptr_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ae_q <= 1'b1;
      else         ae_q <= (32'(lvl_d) <= AE_THRESH);
   end

   assign level_o        = wr_ptr_q - rd_ptr_q;
   assign almost_empty_o = ae_q;
`endif

endmodule
